// File: rtl/raw_line_window_buffer.sv
// raw_line_window_buffer: N-line circular line buffer for raw Bayer pixels.
//   It keeps NUM_TAPS-1 line memories and, for every accepted pixel, emits
//   the vertical column made of the current pixel and the same column of
//   the NUM_TAPS-1 previous lines.
// Latency: TAP_DATA / TAP_VALID / COL_ADDR are registered and appear 1 cycle
//   after the pixel is accepted.
// Backpressure: none. The input is always accepted. A pixel beyond LINE_WIDTH
//   is dropped and sets the sticky OVERFLOW flag.
//
// Ports:
//   CLK, RESET  : sole clock; synchronous active-high reset
//   VSYNC/HSYNC : sync levels; rising edges mark frame start / line end
//   PIX_VALID, DATA_IN : incoming raw pixel
//   TAP_DATA    : tap k at [k*DATA_WIDTH +: DATA_WIDTH]; tap0 = current line
//   TAP_VALID, COL_ADDR : window qualifier and its column
//   LINE_READY  : NUM_TAPS-1 complete lines are held
//   OVERFLOW    : sticky; a line exceeded LINE_WIDTH (cleared by frame start)
// Optional macro LWB_BAYER_PHASE_EN: adds ROW_ODD / COL_ODD phase outputs
//   that are aligned with TAP_DATA.
module raw_line_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_WIDTH = 1024,
  parameter int NUM_TAPS   = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           VSYNC,
  input  logic                           HSYNC,
  input  logic                           PIX_VALID,
  input  logic [DATA_WIDTH-1:0]          DATA_IN,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] TAP_DATA,
  output logic                           TAP_VALID,
  output logic [ADDR_WIDTH-1:0]          COL_ADDR,
  output logic                           LINE_READY,
  output logic                           OVERFLOW
`ifdef LWB_BAYER_PHASE_EN
  ,
  output logic                           ROW_ODD,
  output logic                           COL_ODD
`endif
);

  localparam int NUM_MEMS = NUM_TAPS - 1;
  localparam int WP_W     = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
  localparam int CNT_W    = ADDR_WIDTH + 1;  // must be able to hold LINE_WIDTH itself
  localparam int LS_W     = $clog2(NUM_TAPS);

  localparam logic [CNT_W-1:0] LINE_MAX = CNT_W'(LINE_WIDTH);
  localparam logic [LS_W-1:0]  LS_FULL  = LS_W'(NUM_MEMS);
  localparam logic [WP_W-1:0]  WP_LAST  = WP_W'(NUM_MEMS - 1);

  // Line storage. It is not reset, because stale contents are never
  // exposed: TAP_VALID waits until NUM_MEMS lines of the frame are written.
  logic [DATA_WIDTH-1:0] mem [NUM_MEMS][LINE_WIDTH];

  logic                  vs_d, hs_d;
  logic [CNT_W-1:0]      col_cnt;
  logic [WP_W-1:0]       wp;
  logic [LS_W-1:0]       lines_seen;

  logic                  vs_rise, hs_rise, line_end;
  logic [CNT_W-1:0]      col_eff;
  logic [WP_W-1:0]       wp_eff;
  logic [LS_W-1:0]       ls_eff;
  logic                  accept, drop, emit;
  logic [ADDR_WIDTH-1:0] rd_col;
  logic [WP_W-1:0]       tap_idx;
  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_next;

  assign vs_rise  = VSYNC & ~vs_d;
  assign hs_rise  = HSYNC & ~hs_d;
  // An edge on an empty line (col_cnt == 0) is a duplicate and does not rotate.
  assign line_end = ~vs_rise & hs_rise & (col_cnt != '0);

  // Edge processing comes before the pixel of the same cycle, so a pixel
  // that coincides with an edge becomes column 0 of the new line.
  always_comb begin
    col_eff = col_cnt;
    wp_eff  = wp;
    ls_eff  = lines_seen;
    if (vs_rise) begin
      col_eff = '0;
      wp_eff  = '0;
      ls_eff  = '0;
    end else if (line_end) begin
      col_eff = '0;
      wp_eff  = (wp == WP_LAST) ? '0 : wp + WP_W'(1);
      ls_eff  = (lines_seen == LS_FULL) ? lines_seen : lines_seen + LS_W'(1);
    end
  end

  assign accept = PIX_VALID & (col_eff < LINE_MAX);
  assign drop   = PIX_VALID & ~(col_eff < LINE_MAX);
  assign emit   = accept & (ls_eff == LS_FULL);
  assign rd_col = col_eff[ADDR_WIDTH-1:0];

  // Read all memories at the current column. The write below is a
  // non-blocking update, so memory wp still returns the oldest line here.
  always_comb begin
    tap_next                   = '0;
    tap_idx                    = '0;
    tap_next[DATA_WIDTH-1:0]   = DATA_IN;
    for (int k = 1; k < NUM_TAPS; k++) begin
      tap_idx = WP_W'((int'(wp_eff) + NUM_MEMS - k) % NUM_MEMS);
      tap_next[k*DATA_WIDTH +: DATA_WIDTH] = mem[tap_idx][rd_col];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && accept) begin
      mem[wp_eff][rd_col] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      col_cnt    <= '0;
      wp         <= '0;
      lines_seen <= '0;
      TAP_DATA   <= '0;
      TAP_VALID  <= 1'b0;
      COL_ADDR   <= '0;
      LINE_READY <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      vs_d       <= VSYNC;
      hs_d       <= HSYNC;
      col_cnt    <= accept ? col_eff + CNT_W'(1) : col_eff;
      wp         <= wp_eff;
      lines_seen <= ls_eff;
      OVERFLOW   <= (OVERFLOW & ~vs_rise) | drop;
      LINE_READY <= (ls_eff == LS_FULL);
      TAP_VALID  <= emit;
      if (emit) begin
        TAP_DATA <= tap_next;
        COL_ADDR <= rd_col;
      end
    end
  end

`ifdef LWB_BAYER_PHASE_EN
  logic row_par;
  logic row_par_eff;

  always_comb begin
    row_par_eff = row_par;
    if (vs_rise) begin
      row_par_eff = 1'b0;
    end else if (line_end) begin
      row_par_eff = ~row_par;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_par <= 1'b0;
      ROW_ODD <= 1'b0;
      COL_ODD <= 1'b0;
    end else begin
      row_par <= row_par_eff;
      if (emit) begin
        ROW_ODD <= row_par_eff;
        COL_ODD <= rd_col[0];
      end else if (vs_rise) begin
        ROW_ODD <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_raw_line_window_buffer.sv
// Bench for raw_line_window_buffer.
// The reference keeps the frame as a queue of completed lines plus the
// line being built, and compares the DUT against it on every cycle.
module tb_raw_line_window_buffer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int LW = 8;
  localparam int NT = 3;

  logic              CLK = 1'b0;
  logic              RESET, VSYNC, HSYNC, PIX_VALID;
  logic [DW-1:0]     DATA_IN;
  logic [NT*DW-1:0]  TAP_DATA;
  logic              TAP_VALID, LINE_READY, OVERFLOW;
  logic [AW-1:0]     COL_ADDR;

  raw_line_window_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_TAPS(NT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .PIX_VALID(PIX_VALID), .DATA_IN(DATA_IN), .TAP_DATA(TAP_DATA),
    .TAP_VALID(TAP_VALID), .COL_ADDR(COL_ADDR), .LINE_READY(LINE_READY),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [DW-1:0] line_t [LW];
  line_t         frame_lines[$];   // completed lines, oldest first
  logic [DW-1:0] cur[$];           // pixels of the line being received
  line_t         tmp_line;
  logic          prev_vs, prev_hs, live;
  logic          vr, hr;
  logic [NT*DW-1:0] exp_tap;
  logic          exp_tv, exp_lr, exp_ovf;
  logic [AW-1:0] exp_col;

  initial live = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      live = 1'b1;
      frame_lines.delete();
      cur.delete();
      prev_vs = 1'b0; prev_hs = 1'b0;
      exp_tap = '0; exp_tv = 1'b0; exp_lr = 1'b0; exp_ovf = 1'b0; exp_col = '0;
    end else if (live) begin
      vr = VSYNC && !prev_vs;
      hr = HSYNC && !prev_hs;
      prev_vs = VSYNC;
      prev_hs = HSYNC;
      if (vr) begin
        frame_lines.delete();
        cur.delete();
        exp_ovf = 1'b0;
      end else if (hr && cur.size() > 0) begin
        for (int i = 0; i < LW; i++) tmp_line[i] = (i < cur.size()) ? cur[i] : '0;
        frame_lines.push_back(tmp_line);
        if (frame_lines.size() > NT-1) void'(frame_lines.pop_front());
        cur.delete();
      end
      exp_tv = 1'b0;
      if (PIX_VALID) begin
        if (cur.size() < LW) begin
          if (frame_lines.size() == NT-1) begin
            exp_tv = 1'b1;
            exp_col = AW'(cur.size());
            exp_tap[0 +: DW] = DATA_IN;
            for (int k = 1; k < NT; k++)
              exp_tap[k*DW +: DW] = frame_lines[frame_lines.size()-k][cur.size()];
          end
          cur.push_back(DATA_IN);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      exp_lr = (frame_lines.size() == NT-1);
    end
  end

  always @(negedge CLK) begin
    if (live) begin
      chk("tap_valid",  TAP_VALID,  exp_tv);
      chk("tap_data",   TAP_DATA,   exp_tap);
      chk("col_addr",   COL_ADDR,   exp_col);
      chk("line_ready", LINE_READY, exp_lr);
      chk("overflow",   OVERFLOW,   exp_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Sync levels are one-cycle pulses: they drop after every clock edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    VSYNC = 1'b0;
    HSYNC = 1'b0;
  endtask

  task automatic pix(input logic [DW-1:0] v);
    PIX_VALID = 1'b1;
    DATA_IN   = v;
    tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic hs();
    HSYNC = 1'b1;
    tick();
  endtask

  task automatic vs();
    VSYNC = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Frame of lines 0..2 with value line*16+col, checked against literals.
  task automatic run_s1(input string tag);
    vs();
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < LW; c++) begin
        pix(DW'(l*16 + c));
        if (l < 2 && c == 0) chk({tag, "_early_tv"}, TAP_VALID, 0);
        if (l == 2) begin
          chk({tag, "_tv"},  TAP_VALID, 1);
          chk({tag, "_tap"}, TAP_DATA, {DW'(c), DW'(16 + c), DW'(32 + c)});
          chk({tag, "_col"}, COL_ADDR, c);
        end
      end
      hs();
      if (l == 0) chk({tag, "_lr_l0"}, LINE_READY, 0);
      if (l == 1) chk({tag, "_lr_l1"}, LINE_READY, 1);
    end
  endtask

  int nlines, extra, len, hv;
  logic cut;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; PIX_VALID = 1'b0; DATA_IN = '0;
    #1;
    tick(); tick();
    chk("rst_tv",   TAP_VALID,  0);
    chk("rst_tap",  TAP_DATA,   0);
    chk("rst_col",  COL_ADDR,   0);
    chk("rst_lr",   LINE_READY, 0);
    chk("rst_ovf",  OVERFLOW,   0);
    RESET = 1'b0;
    idle(2);

    // Scenario 1 and 2: first window and pointer wrap / read-first.
    run_s1("s1");
    for (int c = 0; c < LW; c++) begin
      pix(DW'(16'h30 + c));
      chk("s2_tap", TAP_DATA, {DW'(16'h10 + c), DW'(16'h20 + c), DW'(16'h30 + c)});
    end
    hs();

    // Scenario 3: overflow on a 9-pixel line.
    for (int c = 0; c < LW + 1; c++) begin
      pix(DW'(16'h40 + c));
      if (c == LW) begin
        chk("s3_drop_tv", TAP_VALID, 0);
        chk("s3_ovf",     OVERFLOW,  1);
      end
    end
    hs();
    for (int c = 0; c < LW; c++) pix(DW'(16'h50 + c));
    chk("s3_ovf_sticky", OVERFLOW, 1);
    hs();
    vs();
    chk("s3_ovf_clr", OVERFLOW,   0);
    chk("s3_lr_clr",  LINE_READY, 0);

    // Scenario 4: frame start in the middle of line 3.
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < LW; c++) pix(DW'(16'h100 + l*16 + c));
      hs();
    end
    for (int c = 0; c < 4; c++) pix(DW'(16'h130 + c));
    vs();
    chk("s4_lr", LINE_READY, 0);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < LW; c++) begin
        pix(DW'(16'h200 + l*16 + c));
        if (c == 0) chk("s4_tv", TAP_VALID, (l == 2));
        if (l == 2 && c == 0) chk("s4_col", COL_ADDR, 0);
      end
      hs();
    end

    // Scenario 5: VSYNC+HSYNC+pixel together, then a duplicate HSYNC edge.
    VSYNC = 1'b1; HSYNC = 1'b1;
    pix(DW'(16'hABC));
    chk("s5_tv", TAP_VALID,  0);
    chk("s5_lr", LINE_READY, 0);
    for (int c = 1; c < LW; c++) pix(DW'(16'h500 + c));
    hs(); idle(1); hs();
    for (int c = 0; c < LW; c++) begin
      pix(DW'(16'h510 + c));
      if (c == 0) chk("s5_dup_tv", TAP_VALID, 0);
    end
    hs();
    pix(DW'(16'h520));
    chk("s5_tv2",  TAP_VALID, 1);
    chk("s5_tap2", TAP_DATA[2*DW +: DW], 16'hABC);
    for (int c = 1; c < LW; c++) pix(DW'(16'h520 + c));
    hs();

    // Scenario 6: reset mid-line with a pixel present.
    for (int c = 0; c < 3; c++) pix(DW'(16'h600 + c));
    RESET = 1'b1; PIX_VALID = 1'b1; DATA_IN = 16'h77;
    tick();
    RESET = 1'b0; PIX_VALID = 1'b0;
    chk("s6_tv",  TAP_VALID,  0);
    chk("s6_tap", TAP_DATA,   0);
    chk("s6_col", COL_ADDR,   0);
    chk("s6_lr",  LINE_READY, 0);
    chk("s6_ovf", OVERFLOW,   0);
    run_s1("s6");

    // Randomized frames: gaps, overflow lines, duplicate / coincident
    // HSYNC edges and frames cut short by VSYNC.
    for (int f = 0; f < 30; f++) begin
      vs();
      nlines = $urandom_range(2, 5);
      for (int l = 0; l < nlines; l++) begin
        cut   = ($urandom_range(0, 7) == 0);
        extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
        len   = cut ? $urandom_range(1, LW-1) : LW + extra;
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          pix(DW'($urandom_range(0, 65535)));
        end
        if (cut) break;
        hv = $urandom_range(0, 2);
        if (hv == 0) hs();
        else if (hv == 1) begin hs(); idle(1); hs(); end
        else HSYNC = 1'b1;  // edge rides on the next pixel, idle or VSYNC
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
